muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage. It executes MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU on WIDTH-bit operands, producing a 2·WIDTH {HI,LO} result. The multiplier is iterative with a configurable number of bits per cycle; the divider is radix-2 restoring. EX drives it through a start/done handshake and uses `busy_o` to form its stall request; the pipeline flush aborts an operation in flight.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_div_iter.sv | 58 +++++
 rtl/muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared operation codes, FSM state encoding and op-class helpers for muldiv_unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } muldiv_op_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic op_is_signed(input muldiv_op_e op);
    logic s;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB, OP_DIV: s = 1'b1;
      default:                           s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    logic d;
    case (op)
      OP_DIV, OP_DIVU: d = 1'b1;
      default:         d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   trial_s;

  // The dividend shifts out of quo_r MSB-first while quotient bits shift in at the bottom.
  assign trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};

  // Shift/subtract register and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load_i) begin
      quo_r <= dividend_i;
      rem_r <= {WIDTH{1'b0}};
      dvs_r <= divisor_i;
      cnt_r <= {CW{1'b0}};
    end else if (step_i) begin
      if (!trial_s[WIDTH]) begin
        rem_r <= trial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign quotient_o  = quo_r;
  assign remainder_o = rem_r;
  assign last_o      = (cnt_r == LAST_CNT);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / restoring divide unit for EX with start/done handshake and flush abort.
// Optional divider: define MULDIV_DIV_EN; otherwise DIV/DIVU complete at once with dbz set and result 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  muldiv_op_e         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dbz_o
);

  localparam int DW  = 2 * WIDTH;
  localparam int N   = WIDTH / MUL_STEP;
  localparam int MCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(N - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  muldiv_op_e       op_r;
  logic             sign_a_r;
  logic             sign_b_r;
  logic [DW-1:0]    hilo_r;
  logic [DW-1:0]    mcand_r;
  logic [DW-1:0]    prod_r;
  logic [WIDTH-1:0] mplier_r;
  logic [MCW-1:0]   mcnt_r;
  logic [DW-1:0]    result_r;
  logic             dbz_r;
  logic             busy_r;
  logic             done_r;

  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             accept_s;
  logic             dbz_take_s;
  logic [DW-1:0]    dbz_res_s;
  logic [DW-1:0]    pp_s;
  logic [DW-1:0]    prod_fix_s;
  logic [DW-1:0]    fix_s;

  assign sign_a_s = op_is_signed(op_i) & opa_i[WIDTH-1];
  assign sign_b_s = op_is_signed(op_i) & opb_i[WIDTH-1];
  assign abs_a_s  = sign_a_s ? (~opa_i + 1'b1) : opa_i;
  assign abs_b_s  = sign_b_s ? (~opb_i + 1'b1) : opb_i;
  assign accept_s = start_i & ~flush_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign pp_s     = mcand_r * {{(DW-MUL_STEP){1'b0}}, mplier_r[MUL_STEP-1:0]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             div_step_s;
  logic             div_last_s;

  assign dbz_take_s = accept_s & op_is_div(op_i) & (opb_i == {WIDTH{1'b0}});
  assign dbz_res_s  = {opa_i, {WIDTH{1'b1}}};
  assign div_step_s = (state_r == ST_DIV);
  // Remainder follows the dividend's sign; quotient negates when signs differ.
  assign quo_fix_s  = (sign_a_r ^ sign_b_r) ? (~quo_s + 1'b1) : quo_s;
  assign rem_fix_s  = sign_a_r ? (~rem_s + 1'b1) : rem_s;

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept_s),
    .step_i     (div_step_s),
    .dividend_i (abs_a_s),
    .divisor_i  (abs_b_s),
    .quotient_o (quo_s),
    .remainder_o(rem_s),
    .last_o     (div_last_s)
  );
`else
  assign dbz_take_s = accept_s & op_is_div(op_i);
  assign dbz_res_s  = {DW{1'b0}};
`endif

  // Next-state selection; flush wins over any start or progress.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            case (op_i)
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: state_nxt_s = ST_MUL;
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: state_nxt_s = dbz_take_s ? ST_DONE : ST_DIV;
`else
              OP_DIV, OP_DIVU: state_nxt_s = ST_DONE;
`endif
              default: state_nxt_s = ST_IDLE;
            endcase
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mcnt_r == MUL_LAST) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_MUL;
          end
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (div_last_s) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end
`endif
        ST_FIX:  state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Sign and accumulator fix-up applied in the FIX cycle.
  always_comb begin
    prod_fix_s = (sign_a_r ^ sign_b_r) ? (~prod_r + 1'b1) : prod_r;
    fix_s      = prod_fix_s;
    case (op_r)
      OP_MADD, OP_MADDU: fix_s = hilo_r + prod_fix_s;
      OP_MSUB, OP_MSUBU: fix_s = hilo_r - prod_fix_s;
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:   fix_s = {rem_fix_s, quo_fix_s};
`endif
      default:           fix_s = prod_fix_s;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_MUL) | (state_nxt_s == ST_DIV) | (state_nxt_s == ST_FIX);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture on accept; shift-and-add multiply while in MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= OP_MULT;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hilo_r   <= {DW{1'b0}};
      mcand_r  <= {DW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {DW{1'b0}};
      mcnt_r   <= {MCW{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_i;
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      hilo_r   <= hilo_i;
      mcand_r  <= {{WIDTH{1'b0}}, abs_a_s};
      mplier_r <= abs_b_s;
      prod_r   <= {DW{1'b0}};
      mcnt_r   <= {MCW{1'b0}};
    end else if (state_r == ST_MUL) begin
      prod_r   <= prod_r + pp_s;
      mcand_r  <= mcand_r << MUL_STEP;
      mplier_r <= mplier_r >> MUL_STEP;
      mcnt_r   <= mcnt_r + 1'b1;
    end
  end

  // Result and divide-by-zero flag change only when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {DW{1'b0}};
      dbz_r    <= 1'b0;
    end else if (flush_i) begin
      result_r <= result_r;
      dbz_r    <= dbz_r;
    end else if (state_r == ST_FIX) begin
      result_r <= fix_s;
      dbz_r    <= 1'b0;
    end else if (dbz_take_s) begin
      result_r <= dbz_res_s;
      dbz_r    <= 1'b1;
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;
  assign dbz_o    = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32, MUL_STEP=4.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 10;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  muldiv_op_e  op_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic [63:0] hilo_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;
  logic        dbz_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .hilo_i  (hilo_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o),
    .dbz_o   (dbz_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    hilo_i  = h;
  endtask

  // Called at the negedge where start was driven; returns at the negedge showing done.
  task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_res,
                           input logic exp_dbz);
    int lat;
    lat = 0;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0;
        if (exp_lat > 1) check({tag, "_busy"}, {63'd0, busy_o}, 64'd1);
      end
      if (done_o) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_dbz"}, {63'd0, dbz_o}, {63'd0, exp_dbz});
  endtask

  task automatic div_case(input string tag, input muldiv_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res);
    @(negedge clk);
    start_op(op, a, b, 64'd0);
`ifdef MULDIV_DIV_EN
    wait_done(tag, DIV_LAT, exp_res, 1'b0);
`else
    wait_done(tag, 1, 64'd0, 1'b1);
`endif
  endtask

  logic [63:0] dbz_exp;
  logic        saw_done;
  muldiv_op_e  flush_op;

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = OP_MULT;
    opa_i   = 32'd0;
    opb_i   = 32'd0;
    hilo_i  = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_res", result_o, 64'd0);
    check("rst_dbz", {63'd0, dbz_o}, 64'd0);
    rst = 1'b0;

    @(negedge clk);
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'd0);
    wait_done("mult", MUL_LAT, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

    @(negedge clk);
    start_op(OP_MADDU, 32'd2, 32'd1, 64'h0000_0001_FFFF_FFFF);
    wait_done("maddu", MUL_LAT, 64'h0000_0002_0000_0001, 1'b0);

    @(negedge clk);
    start_op(OP_MSUB, 32'd3, 32'd4, 64'd0);
    wait_done("msub", MUL_LAT, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    wait_done("b2b_multu", MUL_LAT, 64'hFFFF_FFFE_0000_0001, 1'b0);

    @(negedge clk);
    start_op(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd0);
    wait_done("mult_negneg", MUL_LAT, 64'd6, 1'b0);

    @(negedge clk);
    start_op(OP_MADD, 32'hFFFF_FFFE, 32'd3, 64'd10);
    wait_done("madd_neg", MUL_LAT, 64'd4, 1'b0);

    div_case("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    div_case("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    div_case("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    div_case("divu", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

`ifdef MULDIV_DIV_EN
    dbz_exp  = 64'h0000_0005_FFFF_FFFF;
    flush_op = OP_DIVU;
`else
    dbz_exp  = 64'd0;
    flush_op = OP_MULTU;
`endif
    @(negedge clk);
    start_op(OP_DIVU, 32'd5, 32'd0, 64'd0);
    wait_done("divu_dbz", 1, dbz_exp, 1'b1);

    // Flush in cycle 4, then a fresh start in cycle 5.
    @(negedge clk);
    start_op(flush_op, 32'd1000, 32'd3, 64'd0);
    saw_done = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      if (done_o) saw_done = 1'b1;
      if (c == 4) flush_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0;
    if (done_o) saw_done = 1'b1;
    check("flush_busy", {63'd0, busy_o}, 64'd0);
    check("flush_nodone", {63'd0, saw_done}, 64'd0);
    check("flush_hold_res", result_o, dbz_exp);
    check("flush_hold_dbz", {63'd0, dbz_o}, 64'd1);
    start_op(OP_MULTU, 32'd7, 32'd6, 64'd0);
    wait_done("after_flush", MUL_LAT, 64'd42, 1'b0);

    // Reset in the middle of a multiply clears everything.
    @(negedge clk);
    start_op(OP_MULT, 32'd3, 32'd3, 64'd0);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_res", result_o, 64'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
